// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
// Scan sequencer for a multi-digit 7-segment display with a shared segment
// bus. A display word is taken through a valid/ready handshake into a shadow
// register and committed to the display register only at frame boundaries.
// Each digit gets a blanking interval (all anodes off) followed by a drive
// interval.
// Optional feature: define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [4*NUM_DIGITS-1:0] i_hex,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  // Inactive levels of the pins; XOR with these converts active-high to pin polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic                  DP_OFF  = ACTIVE_LOW;

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  // With no blanking interval the sequencer lives entirely in DRIVE.
  localparam state_t RST_STATE = state_t'((BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE);

  // Active-high gfedcba patterns for hex 0-F.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  state_t                  state_q, state_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    run_q;
  logic [4*NUM_DIGITS-1:0] sh_hex_q, sh_hex_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    full_q, full_d;
  logic [4*NUM_DIGITS-1:0] disp_hex_q, disp_hex_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;
  logic                    accept, commit;
  logic [3:0]              nib;

  // Scan sequencing: blank/drive intervals, digit advance and frame detection.
  // The first edge after reset is treated as entry into digit 0.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q + 1'b1;
    frame_d = 1'b0;
    if (!run_q) begin
      state_d = RST_STATE;
      digit_d = '0;
      cnt_d   = '0;
      frame_d = 1'b1;
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_DRIVE;
        cnt_d   = '0;
      end
    end else if (cnt_q == DWELL_LAST) begin
      cnt_d   = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
      if (BLANK_CYCLES > 0) begin
        state_d = ST_BLANK;
      end else begin
        state_d = ST_DRIVE;
      end
      frame_d = (digit_q == DIG_LAST);
    end
  end

  // Handshake and shadow-to-display commit; a word accepted on a boundary
  // waits for the next boundary because commit looks at the old full flag.
  always_comb begin
    accept     = i_valid && !full_q;
    commit     = frame_d && full_q;
    sh_hex_d   = accept ? i_hex : sh_hex_q;
    sh_dp_d    = accept ? i_dp : sh_dp_q;
    full_d     = accept | (full_q & ~commit);
    disp_hex_d = commit ? sh_hex_q : disp_hex_q;
    disp_dp_d  = commit ? sh_dp_q : disp_dp_q;
  end

  // Pin values for the upcoming state, built from the freshly committed word.
`ifdef SEG7_SCAN_LZB_EN
  logic lz_blank;
`endif
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    nib   = disp_hex_d[{digit_d, 2'b00} +: 4];
`ifdef SEG7_SCAN_LZB_EN
    lz_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(digit_d) && disp_hex_d[4*k +: 4] != 4'h0) lz_blank = 1'b0;
    end
`endif
    if (state_d == ST_DRIVE) begin
      an_d  = AN_OFF ^ (NUM_DIGITS'(1) << digit_d);
      seg_d = hex_decode(nib) ^ SEG_OFF;
      dp_d  = disp_dp_d[digit_d] ^ DP_OFF;
`ifdef SEG7_SCAN_LZB_EN
      if (digit_d != '0 && lz_blank) seg_d = SEG_OFF;
`endif
    end
  end

  // State, data and registered pin outputs; reset drops any pending word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= RST_STATE;
      digit_q    <= '0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      sh_hex_q   <= '0;
      sh_dp_q    <= '0;
      full_q     <= 1'b0;
      disp_hex_q <= '0;
      disp_dp_q  <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      run_q      <= 1'b1;
      sh_hex_q   <= sh_hex_d;
      sh_dp_q    <= sh_dp_d;
      full_q     <= full_d;
      disp_hex_q <= disp_hex_d;
      disp_dp_q  <= disp_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign o_ready = ~full_q;
  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller (4 digits, dwell 4, blank 1,
// active-low). A timeline model predicts each cycle's pins from the position
// inside the frame period; a monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_seg7_scan_controller;

  localparam int ND     = 4;
  localparam int DW     = 4;
  localparam int BL     = 1;
  localparam int SLOT   = BL + DW;
  localparam int PERIOD = ND * SLOT;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [15:0] i_hex = '0;
  logic [3:0]  i_dp = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  seg7_scan_controller #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_hex  (i_hex),
    .i_dp   (i_dp),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_an   (o_an),
    .o_seg  (o_seg),
    .o_dp   (o_dp),
    .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    logic       ready;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  logic [6:0] hex_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: edges since reset release, pending and displayed words.
  int          m_n = 0;
  bit          m_full = 1'b0;
  logic [15:0] m_pend_hex = '0;
  logic [15:0] m_disp_hex = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [3:0]  m_disp_dp = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int dg);
    logic [6:0] pat;
    int nibv;
    nibv = int'((v >> (4 * dg)) & 16'hF);
    pat  = hex_pat[nibv];
`ifdef SEG7_SCAN_LZB_EN
    if (dg > 0 && (v >> (4 * dg)) == 16'h0) pat = 7'h00;
`endif
    return ~pat;
  endfunction

  // Predict the pins after the coming clock edge from the current inputs.
  task automatic model_edge();
    exp_t e;
    int n, p, dg, ph;
    bit acc, frm;
    n   = m_n + 1;
    p   = (n - 1) % PERIOD;
    dg  = p / SLOT;
    ph  = p % SLOT;
    frm = (p == 0);
    acc = i_valid && !m_full;
    if (frm && m_full) begin
      m_disp_hex = m_pend_hex;
      m_disp_dp  = m_pend_dp;
      m_full     = 1'b0;
    end
    if (acc) begin
      m_pend_hex = i_hex;
      m_pend_dp  = i_dp;
      m_full     = 1'b1;
    end
    e.frame = frm;
    e.ready = !m_full;
    if (ph >= BL) begin
      e.an  = ~(4'b0001 << dg);
      e.seg = exp_seg(m_disp_hex, dg);
      e.dp  = ~m_disp_dp[dg];
    end else begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
    sb_q.push_back(e);
    m_n = n;
  endtask

  task automatic step(input bit v, input logic [15:0] h, input logic [3:0] d);
    i_valid = v;
    i_hex   = h;
    i_dp    = d;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Idle until the current frame position is pos (optionally with an empty shadow).
  task automatic idle_until_pos(input int pos, input bit need_empty);
    for (int i = 0; i < 3 * PERIOD; i++) begin
      if (m_n > 0 && ((m_n - 1) % PERIOD) == pos && (!need_empty || !m_full)) return;
      idle(1);
    end
    checks++;
    errors++;
    $display("FAIL align: frame position %0d not reached", pos);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_an", 16'(o_an), 16'hF);
    chk("rst_seg", 16'(o_seg), 16'h7F);
    chk("rst_dp", 16'(o_dp), 16'h1);
    chk("rst_frame", 16'(o_frame), 16'h0);
    chk("rst_ready", 16'(o_ready), 16'h1);
    sb_q.delete();
    m_n        = 0;
    m_full     = 1'b0;
    m_pend_hex = '0;
    m_disp_hex = '0;
    m_pend_dp  = '0;
    m_disp_dp  = '0;
    i_valid    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: one expected record per clock edge while running.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got no expected entry at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("an", 16'(o_an), 16'(mon_e.an));
        chk("seg", 16'(o_seg), 16'(mon_e.seg));
        chk("dp", 16'(o_dp), 16'(mon_e.dp));
        chk("frame", 16'(o_frame), 16'(mon_e.frame));
        chk("ready", 16'(o_ready), 16'(mon_e.ready));
      end
    end
  end

  logic [15:0] zero_vals [5] = '{16'h0050, 16'h0000, 16'h000A, 16'h1000, 16'h0300};

  initial begin
    @(negedge clk);
    do_reset();
    idle(40);

    // Mid-frame update.
    idle(7);
    step(1'b1, 16'h1234, 4'b0001);
    idle(45);

    // Accept on the o_frame cycle, then accept sampled on the boundary edge.
    idle_until_pos(0, 1'b1);
    step(1'b1, 16'hA5C3, 4'b1010);
    idle_until_pos(PERIOD - 1, 1'b1);
    step(1'b1, 16'h9E0F, 4'b0110);
    idle(2 * PERIOD);

    // Valid held high with changing data.
    for (int i = 0; i < 5 * PERIOD; i++) step(1'b1, 16'($urandom), 4'($urandom));
    idle(PERIOD + 2);

    // Sparse random requests.
    for (int i = 0; i < 400; i++) step(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom));
    idle(PERIOD + 2);

    // Values with leading zeros.
    for (int i = 0; i < 5; i++) begin
      idle_until_pos(SLOT, 1'b1);
      step(1'b1, zero_vals[i], 4'($urandom));
    end
    idle(2 * PERIOD + 2);

    // Reset while driving digit 2 with a pending update.
    idle_until_pos(SLOT, 1'b1);
    step(1'b1, 16'h4C7B, 4'b1111);
    idle_until_pos(2 * SLOT + 2, 1'b0);
    do_reset();
    idle(45);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
